// File: rtl/roz_scan_gen.sv
// Rotate/zoom scan-coordinate generator: CPU-visible affine register bank,
// fixed-point X/Y scan accumulators and a registered tile-coordinate output stage.
module roz_scan_gen #(
  parameter int ACC_W   = 24,
  parameter int FRAC_W  = 12,
  parameter int PLANE_W = 10,
  parameter int TILE_W  = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ce_13m,
  input  logic                            ce_pixel,
  input  logic [3:0]                      VA,
  input  logic [15:0]                     Din,
  output logic [15:0]                     Dout,
  input  logic                            LDSn,
  input  logic                            UDSn,
  input  logic                            SCCSn,
  input  logic                            RW,
  output logic                            DACKn,
  input  logic                            HSYNn,
  input  logic                            VSYNn,
  output logic                            px_valid,
  output logic [PLANE_W-1:0]              px_x,
  output logic [PLANE_W-1:0]              px_y,
  output logic                            px_oob,
  output logic [2*(PLANE_W-TILE_W)-1:0]   map_addr,
  output logic [2*TILE_W-1:0]             fine
);

  localparam int HI_W  = ACC_W - 16;
  localparam int INT_W = ACC_W - FRAC_W;
  localparam logic [INT_W:0] PLANE_LIM = (INT_W+1)'(1) << PLANE_W;

  typedef enum logic [3:0] {
    REG_ORGX_HI = 4'd0,
    REG_ORGX_LO = 4'd1,
    REG_DXX     = 4'd2,
    REG_DYX     = 4'd3,
    REG_ORGY_HI = 4'd4,
    REG_ORGY_LO = 4'd5,
    REG_DXY     = 4'd6,
    REG_DYY     = 4'd7,
    REG_MODE    = 4'd8
  } reg_idx_e;

  typedef struct packed {
    logic [15:0] dxx;
    logic [15:0] dyx;
    logic [15:0] dxy;
    logic [15:0] dyy;
  } inc_t;

  typedef struct packed {
    logic latch;
    logic wrap;
  } mode_t;

  function automatic logic [ACC_W-1:0] sext16(input logic [15:0] v);
    return {{HI_W{v[15]}}, v};
  endfunction

  function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic        uds_n,
                                             input logic        lds_n);
    return {uds_n ? old_v[15:8] : new_v[15:8], lds_n ? old_v[7:0] : new_v[7:0]};
  endfunction

  // Pending bank (CPU side); origins are only consumed at the vsync load.
  logic [ACC_W-1:0] org_x, org_y;
  inc_t             pend_inc, act_inc;
  mode_t            mode;

  logic        sccs_q, dack_q;
  logic        cs_fall;
  logic [15:0] rd_data, wr_val;

  assign cs_fall = ce_13m & sccs_q & ~SCCSn;

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    rd_data = '0;
    case (VA)
      REG_ORGX_HI: rd_data = 16'(org_x[ACC_W-1:16]);
      REG_ORGX_LO: rd_data = org_x[15:0];
      REG_DXX:     rd_data = pend_inc.dxx;
      REG_DYX:     rd_data = pend_inc.dyx;
      REG_ORGY_HI: rd_data = 16'(org_y[ACC_W-1:16]);
      REG_ORGY_LO: rd_data = org_y[15:0];
      REG_DXY:     rd_data = pend_inc.dxy;
      REG_DYY:     rd_data = pend_inc.dyy;
      REG_MODE:    rd_data = {14'd0, mode};
      default:     rd_data = '0;
    endcase
  end

  // Byte-lane merge against the addressed register's current contents.
  assign wr_val = lane_merge(rd_data, Din, UDSn, LDSn);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the bank is plain flops rather than a RAM, so it takes the reset.
      org_x    <= '0;
      org_y    <= '0;
      pend_inc <= '0;
      mode     <= '0;
      sccs_q   <= 1'b1;
      dack_q   <= 1'b1;
      Dout     <= '0;
    end else if (ce_13m) begin
      // NOTE: non-blocking in clocked processes so every flop samples pre-edge values.
      sccs_q <= SCCSn;
      if (cs_fall) begin
        dack_q <= 1'b0;
        if (RW) begin
          Dout <= rd_data;
        end else begin
          case (VA)
            REG_ORGX_HI: org_x[ACC_W-1:16] <= wr_val[HI_W-1:0];
            REG_ORGX_LO: org_x[15:0]       <= wr_val;
            REG_DXX:     pend_inc.dxx      <= wr_val;
            REG_DYX:     pend_inc.dyx      <= wr_val;
            REG_ORGY_HI: org_y[ACC_W-1:16] <= wr_val[HI_W-1:0];
            REG_ORGY_LO: org_y[15:0]       <= wr_val;
            REG_DXY:     pend_inc.dxy      <= wr_val;
            REG_DYY:     pend_inc.dyy      <= wr_val;
            REG_MODE:    mode              <= mode_t'(wr_val[1:0]);
            default:     ;
          endcase
        end
      end else if (SCCSn) begin
        dack_q <= 1'b1;
      end
    end
  end

  // Acknowledge is held low while deselected; the registered flag only shows during a cycle.
  assign DACKn = SCCSn ? 1'b0 : dack_q;

  logic hs_q, vs_q;
  logic hs_rise, vs_rise;

  assign vs_rise = ce_pixel & ~vs_q & VSYNn;
  assign hs_rise = ce_pixel & ~hs_q & HSYNn;

  always_ff @(posedge clk) begin
    if (reset) begin
      act_inc <= '0;
    end else if (!mode.latch || vs_rise) begin
      act_inc <= pend_inc;
    end
  end

  logic [ACC_W-1:0] cur_x, cur_y, row_x, row_y;
  logic [ACC_W-1:0] row_x_nxt, row_y_nxt;

  assign row_x_nxt = row_x + sext16(act_inc.dxy);
  assign row_y_nxt = row_y + sext16(act_inc.dyy);

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      cur_x <= '0;
      cur_y <= '0;
      row_x <= '0;
      row_y <= '0;
    end else if (ce_pixel) begin
      hs_q <= HSYNn;
      vs_q <= VSYNn;
      // Origins come straight from the pending bank: it is what gets latched this cycle.
      if (vs_rise) begin
        row_x <= org_x;
        row_y <= org_y;
        cur_x <= org_x;
        cur_y <= org_y;
      end else if (hs_rise) begin
        row_x <= row_x_nxt;
        row_y <= row_y_nxt;
        cur_x <= row_x_nxt;
        cur_y <= row_y_nxt;
      end else begin
        cur_x <= cur_x + sext16(act_inc.dxx);
        cur_y <= cur_y + sext16(act_inc.dyx);
      end
    end
  end

  logic [INT_W-1:0] int_x, int_y;
  logic             oob_x, oob_y;

  assign int_x = cur_x[ACC_W-1:FRAC_W];
  assign int_y = cur_y[ACC_W-1:FRAC_W];
  assign oob_x = int_x[INT_W-1] | ({1'b0, int_x} >= PLANE_LIM);
  assign oob_y = int_y[INT_W-1] | ({1'b0, int_y} >= PLANE_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      px_valid <= 1'b0;
      px_x     <= '0;
      px_y     <= '0;
      px_oob   <= 1'b0;
    end else begin
      px_valid <= ce_pixel;
      if (ce_pixel) begin
        px_x   <= int_x[PLANE_W-1:0];
        px_y   <= int_y[PLANE_W-1:0];
        px_oob <= ~mode.wrap & (oob_x | oob_y);
      end
    end
  end

  assign map_addr = {px_y[PLANE_W-1:TILE_W], px_x[PLANE_W-1:TILE_W]};
  assign fine     = {px_y[TILE_W-1:0], px_x[TILE_W-1:0]};

endmodule
